// File: rtl/dbl_to_sig16b_if.sv
// Sample-stream bundle between the echo-cancellation datapath and the
// double-to-PCM16 converter.
interface dbl_to_sig16b_if;
  logic [12:0] sampling_cycle_counter;
  logic        enable;
  logic [63:0] double;
  logic [15:0] sig16b;

  modport master (
    output sampling_cycle_counter,
    output enable,
    output double,
    input  sig16b
  );

  modport slave (
    input  sampling_cycle_counter,
    input  enable,
    input  double,
    output sig16b
  );
endinterface

// File: rtl/dbl_to_sig16b.sv
// IEEE-754 binary64 to signed 16-bit PCM: 3-stage pipeline, round-half-even,
// saturating; optional FRAME_ALIGN_EN publishes results only at period start.
module dbl_to_sig16b #(
  parameter int LATENCY = 3
) (
  input logic           clk_operation,
  input logic           rst,
  dbl_to_sig16b_if.slave bus
);

  if (LATENCY != 3) begin : g_latency_check
    $error("dbl_to_sig16b supports LATENCY = 3 only");
  end

  typedef enum logic [1:0] {
    K_ZERO,
    K_SAT,
    K_NUM
  } kind_t;

  // Stage 1: decoded fields
  logic        s1_valid;
  logic        s1_sign;
  logic [10:0] s1_exp;
  logic        s1_frac_nz;
  logic [52:0] s1_sig;

  // Stage 2: classified, shifted magnitude with guard/sticky
  logic        s2_valid;
  logic        s2_sign;
  kind_t       s2_kind;
  logic [15:0] s2_mag;
  logic        s2_guard;
  logic        s2_sticky;

  // Stage 3: final code
  logic        s3_valid;
  logic [15:0] s3_data;

  kind_t       kind_d;
  logic [5:0]  sh;
  logic [52:0] mask;
  logic [15:0] mag_d;
  logic        guard_d;
  logic        sticky_d;

  logic        inc;
  logic [16:0] mag_r;
  logic [15:0] res_d;

  always_comb begin
    // NOTE: every comb output gets a default first so no branch infers a latch.
    kind_d   = K_NUM;
    sh       = 6'(11'd1075 - s1_exp);
    mask     = '0;
    mag_d    = '0;
    guard_d  = 1'b0;
    sticky_d = 1'b0;
    if (s1_exp == 11'h7FF) begin
      kind_d = s1_frac_nz ? K_ZERO : K_SAT;
    end else if (s1_exp < 11'd1022) begin
      kind_d = K_ZERO;
    end else if (s1_exp >= 11'd1038) begin
      // Exactly -32768.0 also lands here and saturates to the same 0x8000.
      kind_d = K_SAT;
    end else begin
      // sh ranges 38..53 here; the integer part always fits 16 bits.
      mask     = (53'd1 << (sh - 6'd1)) - 53'd1;
      mag_d    = 16'(s1_sig >> sh);
      guard_d  = s1_sig[sh - 6'd1];
      sticky_d = |(s1_sig & mask);
    end
  end

  always_comb begin
    inc   = s2_guard & (s2_sticky | s2_mag[0]);
    mag_r = {1'b0, s2_mag} + {16'd0, inc};
    res_d = 16'h0000;
    unique case (s2_kind)
      K_SAT:  res_d = s2_sign ? 16'h8000 : 16'h7FFF;
      K_NUM: begin
        if (!s2_sign && mag_r > 17'd32767)     res_d = 16'h7FFF;
        else if (s2_sign && mag_r > 17'd32768) res_d = 16'h8000;
        else if (s2_sign)                      res_d = 16'd0 - mag_r[15:0];
        else                                   res_d = mag_r[15:0];
      end
      default: res_d = 16'h0000;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the previous stage's pre-edge value.
  always_ff @(posedge clk_operation) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else begin
      s1_valid <= bus.enable;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
    end
  end

  // NOTE: payload registers are not reset; only the valid bits gate their use.
  always_ff @(posedge clk_operation) begin
    s1_sign    <= bus.double[63];
    s1_exp     <= bus.double[62:52];
    s1_frac_nz <= |bus.double[51:0];
    s1_sig     <= (bus.double[62:52] == 11'd0) ? 53'd0 : {1'b1, bus.double[51:0]};

    s2_sign    <= s1_sign;
    s2_kind    <= kind_d;
    s2_mag     <= mag_d;
    s2_guard   <= guard_d;
    s2_sticky  <= sticky_d;

    s3_data    <= res_d;
  end

`ifdef FRAME_ALIGN_EN
  logic [15:0] hold;

  always_ff @(posedge clk_operation) begin
    if (!rst) begin
      hold       <= 16'h0000;
      bus.sig16b <= 16'h0000;
    end else begin
      if (s3_valid) hold <= s3_data;
      // A result finishing on the period-start edge is published immediately.
      if (bus.sampling_cycle_counter == 13'd0)
        bus.sig16b <= s3_valid ? s3_data : hold;
    end
  end
`else
  always_ff @(posedge clk_operation) begin
    if (!rst)          bus.sig16b <= 16'h0000;
    else if (s3_valid) bus.sig16b <= s3_data;
  end
`endif

endmodule

// File: tb/tb_dbl_to_sig16b.sv
// Directed-vector bench for dbl_to_sig16b; covers FRAME_ALIGN_EN when defined.
module tb_dbl_to_sig16b;

  logic clk_operation;
  logic rst;
  int   n_checks;
  int   n_pass;
  logic [15:0] last_exp;

  dbl_to_sig16b_if bus ();

  dbl_to_sig16b #(.LATENCY(3)) dut (
    .clk_operation (clk_operation),
    .rst           (rst),
    .bus           (bus.slave)
  );

  initial clk_operation = 1'b0;
  always #5 clk_operation = ~clk_operation;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Capture one sample, confirm the output has not moved after two edges,
  // then confirm the converted code after the third.
  task automatic convert(input string tag, input logic [63:0] d, input logic [15:0] exp);
    @(negedge clk_operation);
    bus.enable = 1'b1;
    bus.double = d;
    @(negedge clk_operation);
    bus.enable = 1'b0;
    @(negedge clk_operation);
    @(negedge clk_operation);
    check({tag, "_early"}, bus.sig16b, last_exp);
    @(negedge clk_operation);
    check(tag, bus.sig16b, exp);
    last_exp = exp;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    last_exp = 16'h0000;
    bus.sampling_cycle_counter = 13'd0;
    rst        = 1'b0;
    bus.enable = 1'b1;
    bus.double = 64'h3FF0000000000000;

    // Reset with enable held high: nothing captured during reset may emerge.
    repeat (2) @(posedge clk_operation);
    @(negedge clk_operation);
    rst        = 1'b1;
    bus.enable = 1'b0;
    check("reset", bus.sig16b, 16'h0000);
    repeat (4) @(negedge clk_operation);
    check("reset_no_update", bus.sig16b, 16'h0000);

    convert("one",     64'h3FF0000000000000, 16'h0001);
    convert("neg_one", 64'hBFF0000000000000, 16'hFFFF);

    // In-flight conversion dropped by reset.
    @(negedge clk_operation);
    bus.enable = 1'b1;
    bus.double = 64'h4008000000000000;
    @(negedge clk_operation);
    bus.enable = 1'b0;
    rst        = 1'b0;
    repeat (2) @(negedge clk_operation);
    rst = 1'b1;
    check("flight_reset", bus.sig16b, 16'h0000);
    repeat (4) @(negedge clk_operation);
    check("flight_dropped", bus.sig16b, 16'h0000);
    last_exp = 16'h0000;

    convert("half_even_2p5", 64'h4004000000000000, 16'h0002);
    convert("half_even_3p5", 64'h400C000000000000, 16'h0004);
    convert("half_zero",     64'h3FE0000000000000, 16'h0000);
    convert("sat_pos",       64'h40E3880000000000, 16'h7FFF);
    convert("min_exact",     64'hC0E0000000000000, 16'h8000);
    convert("max_exact",     64'h40DFFFC000000000, 16'h7FFF);
    convert("neg_inf",       64'hFFF0000000000000, 16'h8000);
    convert("nan",           64'h7FF8000000000000, 16'h0000);

    // Back-to-back stream 1.0, 2.0, 3.0.
    @(negedge clk_operation);
    bus.enable = 1'b1;
    bus.double = 64'h3FF0000000000000;
    @(negedge clk_operation);
    bus.double = 64'h4000000000000000;
    @(negedge clk_operation);
    bus.double = 64'h4008000000000000;
    @(negedge clk_operation);
    bus.enable = 1'b0;
    check("stream_early", bus.sig16b, 16'h0000);
    @(negedge clk_operation);
    check("stream_1", bus.sig16b, 16'h0001);
    @(negedge clk_operation);
    check("stream_2", bus.sig16b, 16'h0002);
    @(negedge clk_operation);
    check("stream_3", bus.sig16b, 16'h0003);
    last_exp = 16'h0003;

`ifdef FRAME_ALIGN_EN
    // Capture 5.0 mid-period; output must wait for the next period start.
    @(negedge clk_operation);
    bus.sampling_cycle_counter = 13'd10;
    bus.enable = 1'b1;
    bus.double = 64'h4014000000000000;
    for (int i = 11; i < 20; i++) begin
      @(negedge clk_operation);
      bus.enable = 1'b0;
      bus.sampling_cycle_counter = 13'(i);
      check("frame_hold", bus.sig16b, last_exp);
    end
    @(negedge clk_operation);
    bus.sampling_cycle_counter = 13'd0;
    @(negedge clk_operation);
    check("frame_publish", bus.sig16b, 16'h0005);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dbl_to_sig16b.md
Name: dbl_to_sig16b

Overview:
- Converts an IEEE-754 binary64 sample into a signed 16-bit two's-complement PCM sample.
- Sits at the output of the echo-cancellation datapath, after the adaptive filter / echo subtractor, and drives the 16-bit output stream.
- Integer-scale convention, matching the 16-bit-to-double front end: a double value of 1.0 maps to code 0x0001.
- Fixed-latency pipeline, round-to-nearest-even, saturating.

Parameters:
- LATENCY, 3, pipeline depth in clk_operation cycles from input capture to sig16b update. Fixed at 3; any other value is unsupported.

Ports:
- clk_operation  input  1  single clock; all logic is posedge.
- rst  input  1  synchronous, active-low reset.
- sampling_cycle_counter  input  13  position within the current sample period (0 = period start).
- enable  input  1  qualifies double for capture in this cycle.
- double  input  64  IEEE-754 binary64 sample value.
- sig16b  output  16  converted signed sample, registered.

Behaviour:
- Reset (rst=0 at a posedge):
  - sig16b <= 0x0000.
  - All pipeline valid bits cleared.
  - Any in-flight conversion is dropped; no output update follows from it.
- Capture:
  - At a posedge with rst=1 and enable=1, double is registered into stage 1 with valid=1.
  - enable may stay high continuously; each enabled cycle starts a new conversion (throughput 1 per cycle).
- Stage 1: decode sign s, biased exponent E, fraction f. Significand = {1,f}, or 0 when E=0.
- Stage 2: classify and shift.
  - E=2047, f≠0 (NaN): result 0.
  - E=2047, f=0 (±Inf): saturate by sign.
  - E<1022 (|x|<0.5, including zero and denormals): result 0.
  - E≥1038 (|x|≥32768): saturate by sign, except exactly -32768.0 (s=1, E=1038, f=0), which gives 0x8000.
  - Otherwise: right-shift the significand to an integer magnitude, keeping guard bit and sticky bit.
- Stage 3: round and saturate.
  - Round half to even on the magnitude.
  - After rounding: positive magnitude >32767 → 0x7FFF; negative magnitude >32768 → 0x8000.
  - Negate if s=1.
  - -0.0 and values that round to zero give 0x0000.
- Output:
  - sig16b updates at the 3rd posedge after capture (capture at edge N, visible after edge N+3).
  - With no valid result, sig16b holds its value.
- Saturation values: positive → 0x7FFF, negative → 0x8000.
- No combinational path from any input to sig16b.
- sampling_cycle_counter is ignored unless FRAME_ALIGN_EN is defined.

Optional Feature:
- Macro: FRAME_ALIGN_EN.
- Defined:
  - The stage-3 result goes into a hold register.
  - sig16b loads the most recent held result only at a posedge where sampling_cycle_counter==0.
  - Output is stable for a whole sample period.
  - Results completing mid-period are held until the next period start; a newer result overwrites an older unpublished one.
  - Reset clears the hold register to 0.
- Undefined: sig16b updates directly from stage 3 as described under Behaviour; sampling_cycle_counter is unused.

Test Plan:
- Reset: hold rst=0 for 2 cycles with enable=1 and double=0x3FF0000000000000 → sig16b=0x0000, and no update follows after rst is released.
- Basic and sign: 0x3FF0000000000000 (1.0) → 0x0001, 3 cycles after capture; 0xBFF0000000000000 (-1.0) → 0xFFFF.
- Rounding: 0x4004000000000000 (2.5) → 0x0002; 0x400C000000000000 (3.5) → 0x0004; 0x3FE0000000000000 (0.5) → 0x0000.
- Saturation and range edge:
  - 0x40E3880000000000 (40000.0) → 0x7FFF.
  - 0xC0E0000000000000 (-32768.0) → 0x8000.
  - 0x40DFFFC000000000 (32767.0) → 0x7FFF.
  - 0xFFF0000000000000 (-Inf) → 0x8000.
- Special values and back-to-back: 0x7FF8000000000000 (NaN) → 0x0000. Stream 1.0, 2.0, 3.0 on consecutive cycles → sig16b shows 1, 2, 3 on consecutive cycles starting at latency 3.
- FRAME_ALIGN_EN defined: capture 5.0 while counter=10 → sig16b unchanged until the posedge with counter==0, then 0x0005.
